// File: rtl/vec_mem_strided_if.sv
// vec_mem_strided_if: request/response bus of the strided vector memory.
//   Request side : req_valid, req_ready, req_write, req_addr, req_stride,
//                  req_mask, req_wdata (lane i at [i*WORD_W +: WORD_W])
//   Response side: rsp_valid, rsp_ready, rsp_write, rsp_rdata (same packing)
//   master modport: the requester (load-store unit / testbench)
//   slave modport : the memory
interface vec_mem_strided_if #(
   parameter int WORD_W = 32,
   parameter int LANES  = 16,
   parameter int ADDR_W = 9
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_W-1:0]         req_addr;
   logic [ADDR_W-1:0]         req_stride;
   logic [LANES-1:0]          req_mask;
   logic [LANES*WORD_W-1:0]   req_wdata;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic                      rsp_write;
   logic [LANES*WORD_W-1:0]   rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_rdata
   );
endinterface

// File: rtl/vec_mem_strided.sv
// vec_mem_strided: word-addressed RAM serving whole-vector strided loads and
// stores of LANES words per request, LANES_PER_BEAT lanes per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (memory contents are kept)
//   bus : vec_mem_strided_if slave port (request in, response out)
// Lane i address is (addr + i*stride) mod 2**ADDR_W. Masked-off lanes are not
// written and read back as zero. The first response cycle follows the
// acceptance edge by LANES/LANES_PER_BEAT + 1 clocks.
module vec_mem_strided #(
   parameter int WORD_W         = 32,
   parameter int LANES          = 16,
   parameter int ADDR_W         = 9,
   parameter int LANES_PER_BEAT = 4
) (
   input logic               clk,
   input logic               rst,
   vec_mem_strided_if.slave  bus
);
   localparam int BEATS  = LANES / LANES_PER_BEAT;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_q, state_d;
   logic                accept;
   logic [BEAT_W-1:0]   beat_q;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   stride_q;
   logic [LANES-1:0]    mask_q;
   logic [WORD_W-1:0]   wdata_q [LANES];
   logic [WORD_W-1:0]   rdata_q [LANES];
   logic [WORD_W-1:0]   mem     [DEPTH];

   function automatic logic [LANE_W-1:0] lane_of(input logic [BEAT_W-1:0] beat,
                                                 input int unsigned j);
      return LANE_W'(beat * LANES_PER_BEAT + j);
   endfunction

   // Multiplication in ADDR_W bits gives the required silent wrap-around.
   function automatic logic [ADDR_W-1:0] lane_addr(input logic [LANE_W-1:0] lane);
      return addr_q + ADDR_W'(lane) * stride_q;
   endfunction

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (beat_q == BEAT_W'(BEATS - 1)) state_d = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- request capture, beat counter, load data ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q   <= '0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         stride_q <= '0;
         mask_q   <= '0;
         for (int unsigned i = 0; i < LANES; i++) begin
            wdata_q[i] <= '0;
            rdata_q[i] <= '0;
         end
      end else if (accept) begin
         beat_q   <= '0;
         write_q  <= bus.req_write;
         addr_q   <= bus.req_addr;
         stride_q <= bus.req_stride;
         mask_q   <= bus.req_mask;
         for (int unsigned i = 0; i < LANES; i++) begin
            wdata_q[i] <= bus.req_wdata[i*WORD_W +: WORD_W];
            rdata_q[i] <= '0;
         end
      end else if (state_q == BUSY) begin
         beat_q <= beat_q + 1'b1;
         if (!write_q) begin
            for (int unsigned j = 0; j < LANES_PER_BEAT; j++) begin
               rdata_q[lane_of(beat_q, j)] <= mask_q[lane_of(beat_q, j)] ?
                                              mem[lane_addr(lane_of(beat_q, j))] : '0;
            end
         end
      end
   end

   // ---------------- storage (never reset) ----------------
   // Lanes are written in ascending order so the highest enabled lane wins a
   // same-address collision. Gating with rst drops the beat in flight when a
   // reset arrives mid-store.
   always_ff @(posedge clk) begin
      if (state_q == BUSY && write_q && !rst) begin
         for (int unsigned j = 0; j < LANES_PER_BEAT; j++) begin
            if (mask_q[lane_of(beat_q, j)])
               mem[lane_addr(lane_of(beat_q, j))] <= wdata_q[lane_of(beat_q, j)];
         end
      end
   end

   // ---------------- response outputs ----------------
   assign bus.rsp_write = write_q;

   always_comb begin
      bus.rsp_rdata = '0;
      for (int unsigned i = 0; i < LANES; i++)
         bus.rsp_rdata[i*WORD_W +: WORD_W] = rdata_q[i];
   end
endmodule

// File: tb/tb_vec_mem_strided.sv
// tb_vec_mem_strided: self-checking bench for vec_mem_strided. A flat array
// model of the memory is updated/read lane by lane in plain integer
// arithmetic; directed cases plus randomized requests are compared against it.
module tb_vec_mem_strided;
   localparam int WORD_W = 32;
   localparam int LANES  = 16;
   localparam int ADDR_W = 9;
   localparam int LPB    = 4;
   localparam int BEATS  = LANES / LPB;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int DW     = LANES * WORD_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vec_mem_strided_if #(.WORD_W(WORD_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

   vec_mem_strided #(
      .WORD_W(WORD_W), .LANES(LANES), .ADDR_W(ADDR_W), .LANES_PER_BEAT(LPB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   logic [WORD_W-1:0] mdl [DEPTH];
   logic [DW-1:0]     last_rdata;
   int                acc_wait;

   task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] fill_lanes(input logic [WORD_W-1:0] base, input bit inc);
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = inc ? base + WORD_W'(i) : base;
      return v;
   endfunction

   function automatic logic [DW-1:0] rand_lanes();
      logic [DW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = $urandom;
      return v;
   endfunction

   function automatic logic [WORD_W-1:0] lane(input logic [DW-1:0] v, input int i);
      return v[i*WORD_W +: WORD_W];
   endfunction

   // One full transaction: model update, handshake, latency, optional
   // backpressure (with an extra request poked at the busy block), response.
   task automatic do_req(input logic w, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                         input logic [LANES-1:0] m, input logic [DW-1:0] wd,
                         input int hold, input bit poke);
      logic [DW-1:0] exp;
      int n;
      exp = '0;
      for (int i = 0; i < LANES; i++) begin
         int ad;
         ad = (int'(a) + i * int'(s)) % DEPTH;
         if (m[i]) begin
            if (w) mdl[ad] = wd[i*WORD_W +: WORD_W];
            else   exp[i*WORD_W +: WORD_W] = mdl[ad];
         end
      end
      if (w) exp = '0;

      bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
      bus.req_stride = s;   bus.req_mask = m;  bus.req_wdata = wd;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (bus.req_ready) break;
         n++;
         if (n > 20) begin
            check_eq("accept_timeout", DW'(0), DW'(1));
            bus.req_valid = 1'b0;
            return;
         end
      end
      acc_wait = n;
      @(posedge clk); #1;
      // Scramble the request inputs: they must be ignored after acceptance.
      bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_addr = ADDR_W'($urandom);
      bus.req_stride = ADDR_W'($urandom); bus.req_mask = LANES'($urandom); bus.req_wdata = rand_lanes();

      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("latency", DW'(n), DW'(BEATS));
      if (!bus.rsp_valid) return;

      for (int h = 0; h < hold; h++) begin
         if (poke) bus.req_valid = 1'b1;
         @(posedge clk); #1;
         check_eq("bp_valid", DW'(bus.rsp_valid), DW'(1));
         check_eq("bp_ready", DW'(bus.req_ready), DW'(0));
         check_eq("bp_rdata", bus.rsp_rdata, exp);
      end
      check_eq("rdata", bus.rsp_rdata, exp);
      check_eq("rsp_write", DW'(bus.rsp_write), DW'(w));
      last_rdata = bus.rsp_rdata;

      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      check_eq("back_idle", DW'({bus.rsp_valid, bus.req_ready}), DW'(2'b01));
   endtask

   initial begin
      logic [DW-1:0] wd;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_stride = '0;
      bus.req_mask = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
      acc_wait = 0; last_rdata = '0;

      // Reset values.
      #12;
      check_eq("rst_ready", DW'(bus.req_ready), DW'(1));
      check_eq("rst_valid", DW'(bus.rsp_valid), DW'(0));
      check_eq("rst_write", DW'(bus.rsp_write), DW'(0));
      check_eq("rst_rdata", bus.rsp_rdata, '0);
      @(posedge clk); #1 rst = 1'b0;

      // Preload every word with 0xAAAAAAAA.
      for (int k = 0; k < DEPTH / LANES; k++)
         do_req(1'b1, ADDR_W'(k * LANES), ADDR_W'(1), '1, fill_lanes(32'hAAAA_AAAA, 0), 0, 0);

      // Masking.
      do_req(1'b1, '0, ADDR_W'(1), 16'h00F0, fill_lanes(32'h5555_5555, 0), 0, 0);
      do_req(1'b0, '0, ADDR_W'(1), 16'hFFFF, '0, 0, 0);
      check_eq("mask_l4", DW'(lane(last_rdata, 4)), DW'(32'h5555_5555));
      check_eq("mask_l3", DW'(lane(last_rdata, 3)), DW'(32'hAAAA_AAAA));
      do_req(1'b0, '0, ADDR_W'(1), 16'h000F, '0, 0, 0);
      check_eq("mask_l5_zero", DW'(lane(last_rdata, 5)), DW'(0));

      // Contiguous round trip.
      do_req(1'b1, ADDR_W'(9'h010), ADDR_W'(1), '1, fill_lanes(32'h100, 1), 0, 0);
      do_req(1'b0, ADDR_W'(9'h010), ADDR_W'(1), '1, '0, 0, 0);
      check_eq("contig_l5", DW'(lane(last_rdata, 5)), DW'(32'h105));

      // Stride 3 with wrap past the top of memory.
      do_req(1'b1, ADDR_W'(9'h1F8), ADDR_W'(3), '1, fill_lanes(32'h0, 1), 0, 0);
      do_req(1'b0, '0, ADDR_W'(1), '1, '0, 0, 0);
      check_eq("wrap_w1", DW'(lane(last_rdata, 1)), DW'(3));
      check_eq("wrap_w4", DW'(lane(last_rdata, 4)), DW'(4));

      // Collision: stride 0, highest lane wins.
      do_req(1'b1, ADDR_W'(9'h020), '0, '1, fill_lanes(32'h0, 1), 0, 0);
      do_req(1'b0, ADDR_W'(9'h020), ADDR_W'(1), 16'h0001, '0, 0, 0);
      check_eq("collide", DW'(lane(last_rdata, 0)), DW'(15));

      // Backpressure with a second request waiting; it goes in straight after.
      do_req(1'b0, ADDR_W'(9'h010), ADDR_W'(2), '1, '0, 10, 1);
      do_req(1'b0, ADDR_W'(9'h030), ADDR_W'(5), 16'h5A5A, '0, 0, 0);
      check_eq("queued_accept", DW'(acc_wait), DW'(0));

      // Reset while beat 2 of a full store is in flight.
      wd = rand_lanes();
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = ADDR_W'(9'h180);
      bus.req_stride = ADDR_W'(1); bus.req_mask = '1; bus.req_wdata = wd;
      @(negedge clk);
      check_eq("rs_ready", DW'(bus.req_ready), DW'(1));
      @(posedge clk); #1 bus.req_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2 rst = 1'b1;
      #1;
      check_eq("rs_ready_rst", DW'(bus.req_ready), DW'(1));
      check_eq("rs_valid_rst", DW'(bus.rsp_valid), DW'(0));
      check_eq("rs_write_rst", DW'(bus.rsp_write), DW'(0));
      check_eq("rs_rdata_rst", bus.rsp_rdata, '0);
      for (int i = 0; i < 8; i++) mdl[9'h180 + i] = lane(wd, i);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check_eq("rs_no_rsp", DW'(bus.rsp_valid), DW'(0));
      end
      do_req(1'b0, ADDR_W'(9'h180), ADDR_W'(1), '1, '0, 0, 0);

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         do_req(1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom_range(0, 40)),
                LANES'($urandom), rand_lanes(), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vec_mem_strided.md
# vec_mem_strided

Parametrised vector memory for the vector processor datapath: a word-addressed RAM serving whole-vector loads and stores of LANES words per request. Each request carries a base address, a lane stride and a per-lane enable mask. Lanes are processed over several beats, LANES_PER_BEAT words per clock. Sits between the vector register file / load-store unit and backing storage, replacing the fixed 16×32-bit contiguous-only memory.

## Interface
- WORD_W, 32: bits per memory word and per lane
- LANES, 16: words per vector request
- ADDR_W, 9: word address width; depth is 2**ADDR_W words
- LANES_PER_BEAT, 4: lanes accessed per clock; must divide LANES
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  base word address (lane 0)
- req_stride  in  ADDR_W  lane-to-lane address increment, unsigned
- req_mask  in  LANES  per-lane enable; bit i controls lane i
- req_wdata  in  LANES*WORD_W  store data; lane i at [i*WORD_W +: WORD_W]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_write  out  1  echo of req_write for this response
- rsp_rdata  out  LANES*WORD_W  load data, same lane packing

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid, capture write, addr, stride, mask and wdata; clear rsp_rdata; set beat=0; go to BUSY.
- BUSY: req_ready=0. Each cycle processes lanes beat*LANES_PER_BEAT through beat*LANES_PER_BEAT+LANES_PER_BEAT-1, then beat increments. After beat LANES/LANES_PER_BEAT-1, go to RESP.
- Lane address: (addr + i*stride) mod 2**ADDR_W. Truncate to ADDR_W bits; wrap-around is silent and legal.
- Store, lane mask=1: mem[lane addr] <= lane data. Lane mask=0: no write.
- Load, lane mask=1: rsp_rdata lane <= mem[lane addr]. Lane mask=0: lane reads as 0.
- Address collisions within one store (e.g. stride 0): the highest-index enabled lane wins.
- Mask all-zero: still runs every beat and responds; no memory change, load data all 0.
- RESP: rsp_valid=1, with rsp_rdata and rsp_write stable. When rsp_ready=1, go to IDLE. The next request can be accepted the cycle after.
- Reset (any state): go to IDLE; rsp_valid=0, rsp_write=0, rsp_rdata=0, beat=0. Memory contents are not reset. Beats of a store interrupted mid-flight that already completed stay written; the rest are dropped and no response is produced.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0.
- Request accepted at edge T (req_valid and req_ready). The block is in BUSY for cycles T+1 … T+B, where B = LANES/LANES_PER_BEAT.
- rsp_valid rises after edge T+B; latency is B+1 clocks from acceptance to first response cycle. Default B=4, so latency is 5.
- rsp_valid holds until the edge where rsp_ready=1. rsp_ready is ignored outside RESP.
- Throughput with rsp_ready tied high: one request per B+2 cycles.
- Store data of beat k lands at edge T+1+k. A load whose beat follows a store's beat observes the updated value.
- Inputs are sampled only at acceptance; changes to req_* during BUSY or RESP have no effect.

## Test plan
- Contiguous round-trip: store lanes i=0x100+i at addr 0x010, stride 1, mask 0xFFFF. Then load the same → rsp_rdata lane i = 0x100+i; first rsp_valid 5 cycles after acceptance.
- Stride and wrap: store addr 0x1F8, stride 3, mask 0xFFFF, lane i data=i. Then load with stride 1 from 0x000 → word 0x001 holds lane 3 (0x1F8+9 = 0x201 → 0x001), and word 0x004 holds lane 4.
- Masking: preload 0xAAAA_AAAA everywhere. Store mask 0x00F0, data 0x5555_5555 at addr 0, stride 1. Load mask 0xFFFF → lanes 4–7 = 0x5555_5555, others 0xAAAA_AAAA. Load mask 0x000F → lanes 4–15 = 0.
- Collision: store stride 0 at addr 0x020, mask 0xFFFF, lane i data=i → mem[0x020] = 15.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is not accepted. Raise rsp_ready → IDLE next cycle, then the queued request is accepted.
- Reset mid-store: assert rst during beat 2 of a full store → outputs return to reset values immediately; lanes 0–7 written, lanes 8–15 unchanged, no rsp_valid.
